// File: rtl/hvac_zone_arbiter_pkg.sv
// Shared types and default timing constants for the HVAC zone arbiter.
package hvac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    HEAT = 1'b0,
    COOL = 1'b1
  } mode_t;

  localparam int DEF_MIN_DWELL  = 8;
  localparam int DEF_SWITCH_GAP = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hvac_zone_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    int            j;
    logic [IW-1:0] jv;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jv    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jv = IW'(j);
      if (!found && req[jv]) begin
        found     = 1'b1;
        grant[jv] = 1'b1;
        idx       = jv;
      end
    end
  end

endmodule

// File: rtl/hvac_zone_arbiter.sv
// Shares one heating/cooling plant among zones: round-robin grants with a minimum
// dwell per grant and an all-off gap between grants so the plant never short-cycles.
module hvac_zone_arbiter
  import hvac_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int MIN_DWELL  = DEF_MIN_DWELL,
  parameter int SWITCH_GAP = DEF_SWITCH_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ZONES-1:0] heat_req,
  input  logic [N_ZONES-1:0] cool_req,
  output logic [N_ZONES-1:0] zone_grant,
  output logic               plant_heating,
  output logic               plant_cooling
);

  localparam int IW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int CNT_MAX = max2(MIN_DWELL, SWITCH_GAP);
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);
  localparam cnt_t DWELL_C = cnt_t'(MIN_DWELL);
  localparam cnt_t GAP_C   = cnt_t'(SWITCH_GAP);

  state_t             state, state_nxt;
  mode_t              mode, mode_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [IW-1:0]      ptr, ptr_nxt;
  cnt_t               cnt, cnt_nxt;
  logic [N_ZONES-1:0] grant_nxt;
  logic               heat_nxt, cool_nxt;

  logic [N_ZONES-1:0] any_req;
  logic [N_ZONES-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               keep, other_req, launch;

  assign any_req = heat_req | cool_req;

  rr_picker #(.N(N_ZONES), .IW(IW)) u_picker (
    .req   (any_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign other_req = |(any_req & ~zone_grant);
  assign keep      = ((mode == HEAT) ? heat_req[idx] : cool_req[idx]) && !other_req;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    idx_nxt   = idx;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    grant_nxt = '0;
    heat_nxt  = 1'b0;
    cool_nxt  = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: launch = |any_req;
      SERVE: begin
        grant_nxt = zone_grant;
        heat_nxt  = (mode == HEAT);
        cool_nxt  = (mode == COOL);
        if (cnt < DWELL_C) begin
          cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        end else if (!keep) begin
          state_nxt = GAP;
          cnt_nxt   = cnt_t'(1);
          grant_nxt = '0;
          heat_nxt  = 1'b0;
          cool_nxt  = 1'b0;
          ptr_nxt   = (idx == IW'(N_ZONES - 1)) ? '0 : idx + 1'b1;
        end
      end
      GAP: begin
        if (cnt < GAP_C) begin
          cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        end else begin
          // The closing gap edge acts as the IDLE sampling edge, so the all-off
          // window between back-to-back grants is exactly SWITCH_GAP cycles.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          launch    = |any_req;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (launch) begin
      state_nxt = SERVE;
      idx_nxt   = pick_idx;
      mode_nxt  = heat_req[pick_idx] ? HEAT : COOL;
      cnt_nxt   = cnt_t'(1);
      grant_nxt = pick_grant;
      heat_nxt  = heat_req[pick_idx];
      cool_nxt  = !heat_req[pick_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode          <= HEAT;
      idx           <= '0;
      ptr           <= '0;
      cnt           <= '0;
      zone_grant    <= '0;
      plant_heating <= 1'b0;
      plant_cooling <= 1'b0;
    end else begin
      state         <= state_nxt;
      mode          <= mode_nxt;
      idx           <= idx_nxt;
      ptr           <= ptr_nxt;
      cnt           <= cnt_nxt;
      zone_grant    <= grant_nxt;
      plant_heating <= heat_nxt;
      plant_cooling <= cool_nxt;
    end
  end

endmodule

// File: doc/hvac_zone_arbiter.md
HVAC_ZONE_ARBITER -- requirements
Module: hvac_zone_arbiter

Interface
REQ-001 Parameter N_ZONES, default 4, number of requesting zones.
REQ-002 Parameter MIN_DWELL, default 8, minimum clock cycles a grant is held once issued.
REQ-003 Parameter SWITCH_GAP, default 2, clock cycles of all-off between any two grants.
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port heat_req  input  N_ZONES  bit i high: zone i requests heating.
REQ-007 Port cool_req  input  N_ZONES  bit i high: zone i requests cooling.
REQ-008 Port zone_grant  output  N_ZONES  one-hot zone currently served by the shared plant, or all zero.
REQ-009 Port plant_heating  output  1  drives the shared plant into heating.
REQ-010 Port plant_cooling  output  1  drives the shared plant into cooling.

Function
REQ-011 The block SHALL be an FSM with states IDLE, SERVE and GAP, plus a latched mode (HEAT/COOL), a granted-zone index, a round-robin pointer and a cycle counter.
REQ-012 In IDLE, when any bit of (heat_req | cool_req) is high at a rising edge, the block SHALL grant the first requesting zone at or after the pointer (wrapping N_ZONES-1 -> 0) and enter SERVE on that same edge.
REQ-013 A zone asserting both heat_req and cool_req SHALL be granted HEAT.
REQ-014 Grant latency SHALL be one cycle: zone_grant and the plant output become valid on the rising edge that samples the request in IDLE.
REQ-015 In SERVE, plant_heating SHALL equal (mode==HEAT), plant_cooling SHALL equal (mode==COOL), and zone_grant SHALL be one-hot on the granted zone.
REQ-016 SERVE SHALL last at least MIN_DWELL cycles, even if the granted request deasserts, so the plant never short-cycles.
REQ-017 After MIN_DWELL, SERVE SHALL continue only while the granted zone's request for the latched mode is high and no other zone requests; otherwise the block SHALL enter GAP.
REQ-018 On leaving SERVE, the pointer SHALL become (granted index + 1) mod N_ZONES.
REQ-019 In GAP, all outputs SHALL be zero for exactly SWITCH_GAP cycles, after which the block SHALL enter IDLE.
REQ-020 plant_heating and plant_cooling SHALL never be high together, and no heat-to-cool or cool-to-heat change SHALL occur without at least SWITCH_GAP all-off cycles.
REQ-021 In IDLE and GAP, zone_grant SHALL be all zero.
REQ-022 Any unreachable state encoding SHALL return to IDLE on the next edge with all outputs zero.
REQ-023 The dwell/gap counter SHALL be wide enough for max(MIN_DWELL, SWITCH_GAP) and SHALL saturate, never wrap.
REQ-024 Request bits SHALL be sampled only at rising edges; request changes during GAP SHALL not affect the outputs.

Reset
REQ-025 While rst_n is low, the state SHALL be IDLE, the pointer 0, the counter 0, and zone_grant, plant_heating and plant_cooling 0, regardless of clk.
REQ-026 Reset asserted mid-SERVE SHALL clear the plant outputs immediately (asynchronously).
REQ-027 After rst_n deasserts, the first grant SHALL follow REQ-012 with the pointer at 0.

Structure
REQ-028 Package hvac_pkg SHALL hold the state enum (IDLE/SERVE/GAP), the mode enum (HEAT/COOL) and the default MIN_DWELL and SWITCH_GAP constants.
REQ-029 The round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, pointer; outputs: one-hot grant and index), instantiated once.

Verification
REQ-030 Bench SHALL cover: reset, then heat_req=4'b0010 -> one edge later zone_grant=4'b0010, plant_heating=1; heat_req dropped at cycle 2 -> grant held through cycle 8.
REQ-031 Bench SHALL cover: heat_req=4'b0001 and cool_req=4'b0100 held -> zone 0 HEAT for 8 cycles, 2 all-off cycles, then zone 2 COOL; both plant outputs never high together.
REQ-032 Bench SHALL cover: heat_req=4'b1111 held -> grants rotate 0,1,2,3,0, each lasting 8 cycles and separated by 2 all-off cycles.
REQ-033 Bench SHALL cover: heat_req=4'b0100 and cool_req=4'b0100 -> zone 2 granted HEAT.
REQ-034 Bench SHALL cover: rst_n pulled low mid-SERVE, between clock edges -> all outputs 0 at once; after release with cool_req=4'b1000 -> zone 3 granted.
REQ-035 Bench SHALL cover: a single zone alone, heat_req=4'b0001 held 30 cycles -> continuous HEAT grant with no GAP inserted.
